sparsity_flag_writer: RTL
=========================

# sparsity_flag_writer

Producer side of the row-sparsity flag scheme. It accepts a stream of ifmap rows, one row per beat, and derives a 1-bit "row non-zero" flag for each row. Each flag is written into the flag RAM at the row's address, and the flags are OR-reduced into a per-block valid mask. The mask and its non-zero row count are handed to the flag-reading address generator once per column.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per activation word
- ROW_WORDS, 4, activation words per input row beat
- ADDR_WIDTH, 6, flag RAM address width
- ROWS_PER_BLOCK, 8, rows per block; must be a power of two
- NUM_BLOCK, 4, blocks per column; ROWS_PER_COL = ROWS_PER_BLOCK*NUM_BLOCK, and ROWS_PER_COL must be ≤ 2^ADDR_WIDTH

Ports:
- clk, in, 1, single clock, rising edge
- rst, in, 1, reset: synchronous, active-high
- clk_en, in, 1, clock enable; all state frozen while low
- in_valid, in, 1, row beat valid
- in_ready, out, 1, row beat accepted when in_valid && in_ready
- in_data, in, ROW_WORDS*DATA_WIDTH, one ifmap row
- wr_req, out, 1, flag RAM write strobe
- wr_addr, out, ADDR_WIDTH, flag RAM write address
- wr_data, out, 1, flag bit (1 = row contains a non-zero word)
- mask_valid, out, 1, column mask available
- mask_ready, in, 1, consumer takes the mask
- block_valid, out, NUM_BLOCK, bit b = OR of row flags in block b
- nz_rows, out, ADDR_WIDTH+1, count of flagged rows in the column
- column, out, 32, index of the column the mask belongs to

## Operation
- Two states:
  - FILL: accepts rows.
  - HOLD: presents the mask and waits for the consumer.
- in_ready = clk_en && state==FILL.
- On each accepted beat:
  - flag = |in_data.
  - Registered outputs for the next cycle: wr_req_q=1, wr_addr=row_cnt, wr_data=flag.
  - acc[row_cnt / ROWS_PER_BLOCK] |= flag; cnt += flag; row_cnt += 1.
- Accepting the beat with row_cnt == ROWS_PER_COL-1:
  - Load block_valid = acc with the current flag included, and nz_rows = cnt + flag.
  - Set mask_valid=1 and go to HOLD.
  - row_cnt, acc and cnt reset to 0 in the same cycle.
- HOLD:
  - Outputs stay stable.
  - When mask_valid && mask_ready: mask_valid→0, column += 1 (wraps at 2^32), return to FILL next cycle.
  - No row is accepted in the handoff cycle.
- wr_req = wr_req_q && clk_en. wr_req_q clears on any enabled cycle without an accepted beat.
- When clk_en is low:
  - All registers hold, wr_req is 0, and mask_ready is ignored.
  - A pending write is issued on the next enabled cycle.
- Reset:
  - Outputs: in_ready=0 during reset; wr_req=0, wr_addr=0, wr_data=0, mask_valid=0, block_valid=0, nz_rows=0, column=0.
  - Internal state: FILL, row_cnt=0.
  - A partial column in progress is discarded; the flag RAM is not cleared.
- All-zero rows are still written; the flag RAM always receives all ROWS_PER_COL entries per column.

## Timing
- Flag write latency: 1 cycle from the accepting edge. wr_addr and wr_data are valid in the same cycle as wr_req.
- Throughput: 1 row/cycle in FILL. One column takes ROWS_PER_COL cycles plus at least 1 HOLD cycle.
- mask_valid rises 1 cycle after the final row is accepted. That row's flag write is issued in the same cycle that mask_valid rises.
- In the cycle mask_valid rises, the final flag write is on the RAM port in that same cycle. The consumer therefore must not read the flag RAM until the cycle after mask_valid rises.
- in_valid is sampled only in FILL. Data offered in HOLD is held by the source and accepted once state returns to FILL.

## Test plan
- Rows 0..31 all non-zero, mask_ready tied 1 → 32 writes at addresses 0..31 with wr_data=1; block_valid=4'b1111, nz_rows=32, column=0; in_ready low for 1 cycle; the next column reports column=1.
- Only row 9 non-zero (block 1) → block_valid=4'b0010, nz_rows=1; the write at address 9 has wr_data=1 and all other writes have wr_data=0.
- mask_ready held 0 for 5 cycles while in_valid=1 → in_ready=0 and outputs stable throughout; the first row of the next column is accepted 1 cycle after the mask_ready handshake.
- clk_en toggled 0/1 every cycle through a column → identical write sequence and mask as the clk_en=1 run; wr_req never asserted while clk_en=0.
- rst asserted after 12 rows → all outputs at reset values the next cycle; a fresh column of rows 24..31 non-zero gives block_valid=4'b1000, nz_rows=8, column=0.
- Random in_valid gaps with random data over 3 columns → scoreboard match on every write and every mask; column counts 0,1,2.

Source files
------------

// File: rtl/sparsity_flag_writer.sv
// Row-sparsity flag producer: writes one non-zero flag per ifmap row
// and hands a per-block OR mask plus row count to the reader once per column.
module sparsity_flag_writer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ROW_WORDS      = 4,
  parameter int ADDR_WIDTH     = 6,
  parameter int ROWS_PER_BLOCK = 8,
  parameter int NUM_BLOCK      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clk_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROW_WORDS*DATA_WIDTH-1:0] in_data,
  output logic                            wr_req,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic                            wr_data,
  output logic                            mask_valid,
  input  logic                            mask_ready,
  output logic [NUM_BLOCK-1:0]            block_valid,
  output logic [ADDR_WIDTH:0]             nz_rows,
  output logic [31:0]                     column
);

  localparam int ROWS_PER_COL = ROWS_PER_BLOCK * NUM_BLOCK;
  localparam int BLK_SHIFT    = $clog2(ROWS_PER_BLOCK);
  localparam int CW           = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW =
    ADDR_WIDTH'(ROWS_PER_COL - 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] row_cnt_q;
  logic [NUM_BLOCK-1:0]  acc_q;
  logic [CW-1:0]         cnt_q;
  logic                  wr_req_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_data_q;
  logic                  mask_valid_q;
  logic [NUM_BLOCK-1:0]  block_valid_q;
  logic [CW-1:0]         nz_rows_q;
  logic [31:0]           column_q;

  logic                  accept;
  logic                  flag;
  logic                  last_row;
  logic                  handoff;
  logic [ADDR_WIDTH-1:0] blk;
  logic [NUM_BLOCK-1:0]  blk_hit;
  logic [NUM_BLOCK-1:0]  acc_d;
  logic [CW-1:0]         cnt_d;

  assign in_ready = clk_en && !rst && (state_q == FILL);
  assign accept   = in_valid && in_ready;
  assign flag     = |in_data;
  assign last_row = (row_cnt_q == LAST_ROW);
  assign handoff  = clk_en && (state_q == HOLD)
                 && mask_valid_q && mask_ready;
  assign blk      = row_cnt_q >> BLK_SHIFT;

  always_comb begin
    blk_hit = '0;
    for (int b = 0; b < NUM_BLOCK; b++) begin
      blk_hit[b] = (blk == ADDR_WIDTH'(b));
    end
  end

  // Accumulators already including the row accepted this cycle
  assign acc_d = acc_q | (flag ? blk_hit : '0);
  assign cnt_d = cnt_q + CW'(flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      row_cnt_q     <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      wr_req_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 1'b0;
      mask_valid_q  <= 1'b0;
      block_valid_q <= '0;
      nz_rows_q     <= '0;
      column_q      <= '0;
    end else if (clk_en) begin
      wr_req_q <= accept;
      if (accept) begin
        wr_addr_q <= row_cnt_q;
        wr_data_q <= flag;
        if (last_row) begin
          block_valid_q <= acc_d;
          nz_rows_q     <= cnt_d;
          mask_valid_q  <= 1'b1;
          state_q       <= HOLD;
          row_cnt_q     <= '0;
          acc_q         <= '0;
          cnt_q         <= '0;
        end else begin
          row_cnt_q <= row_cnt_q + 1'b1;
          acc_q     <= acc_d;
          cnt_q     <= cnt_d;
        end
      end
      if (handoff) begin
        mask_valid_q <= 1'b0;
        column_q     <= column_q + 32'd1;
        state_q      <= FILL;
      end
    end
  end

  assign wr_req      = wr_req_q && clk_en;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign mask_valid  = mask_valid_q;
  assign block_valid = block_valid_q;
  assign nz_rows     = nz_rows_q;
  assign column      = column_q;

endmodule
